// File: rtl/seq_multiplier_pkg.sv
// Shared types for the iterative multiplier.
//   boolPkg        : two-valued enable type used for internal enables.
//   multiplier2Pkg : operand-mode select, FSM states and product-register
//                    update select.
package boolPkg;
  typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool;
endpackage

package multiplier2Pkg;
  localparam int MUL_WIDTH = 32;

  // Encoding 2'b11 is not assigned and is treated as unsigned.
  typedef enum logic [1:0] {
    MUL_UNSIGNED        = 2'd0,
    MUL_SIGNED          = 2'd1,
    MUL_SIGNED_UNSIGNED = 2'd2
  } mulMux;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mulState;

  typedef enum logic [1:0] {
    LOAD_PRODUCT      = 2'd0,
    ADD_SHIFT_PRODUCT = 2'd1,
    NEG_PRODUCT       = 2'd2,
    HOLD_PRODUCT      = 2'd3
  } productMux;
endpackage

// File: rtl/seq_multiplier_product_state.sv
// Product register and its datapath for the shift-add multiplier.
// Ports:
//   clk, reset        : clock, synchronous active-low reset (clears product)
//   i_sel   [1:0]     : productMux update select
//   i_productEn       : boolPkg::bool, register update enable
//   i_mcand [W-1:0]   : multiplicand magnitude, added while shifting
//   i_mplr  [W-1:0]   : multiplier magnitude, loaded into the low half
//   o_product[2W-1:0] : product register
module seq_multiplier_product_state
  import multiplier2Pkg::*;
  import boolPkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         i_sel,
  input  logic               i_productEn,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplr,
  output logic [2*WIDTH-1:0] o_product
);
  logic [2*WIDTH-1:0] r_product;
  logic [2*WIDTH-1:0] w_next;
  logic [WIDTH:0]     w_sum;

  // Low half doubles as the multiplier shift register: bit 0 is the
  // current multiplier bit, and the sum's carry shifts into the top.
  always_comb begin
    w_sum  = {1'b0, r_product[2*WIDTH-1:WIDTH]}
           + (r_product[0] ? {1'b0, i_mcand} : '0);
    w_next = r_product;
    case (productMux'(i_sel))
      LOAD_PRODUCT:      w_next = {{WIDTH{1'b0}}, i_mplr};
      ADD_SHIFT_PRODUCT: w_next = {w_sum, r_product[WIDTH-1:1]};
      NEG_PRODUCT:       w_next = -r_product;
      default:           w_next = r_product;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)                      r_product <= '0;
    else if (bool'(i_productEn) == TRUE) r_product <= w_next;
  end

  assign o_product = r_product;
endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH sign-magnitude shift-add multiplier,
// one multiplier bit per cycle, start/busy/done handshake.
// Ports:
//   clk, reset                : clock, synchronous active-low reset
//   start                     : request, accepted only in IDLE
//   mulSel [1:0]              : mulMux operand mode, sampled with start
//   multiplicand, multiplier  : operands, sampled with start
//   busy                      : high in every state except IDLE
//   done                      : one-cycle pulse, product valid
//   productHigh, productLow   : product halves, held until next acceptance
module seq_multiplier
  import multiplier2Pkg::*;
  import boolPkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mulSel,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] productHigh,
  output logic [WIDTH-1:0] productLow
);
  localparam int CW = $clog2(WIDTH);

  mulState          r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mcand;
  logic             r_negate;
  logic             r_busy;
  logic             r_done;

  logic               w_signA, w_signB, w_accept;
  logic [WIDTH-1:0]   w_absA, w_absB;
  productMux          w_sel;
  bool                w_productEn;
  logic [2*WIDTH-1:0] w_product;

  always_comb begin
    w_signA = 1'b0;
    w_signB = 1'b0;
    case (mulSel)
      MUL_SIGNED:          begin w_signA = multiplicand[WIDTH-1]; w_signB = multiplier[WIDTH-1]; end
      MUL_SIGNED_UNSIGNED: w_signA = multiplicand[WIDTH-1];
      default: ;
    endcase
  end

  // Most negative value maps to itself, which is its correct magnitude
  // when read as unsigned.
  assign w_absA   = w_signA ? -multiplicand : multiplicand;
  assign w_absB   = w_signB ? -multiplier   : multiplier;
  assign w_accept = (r_state == IDLE) && start;

  always_comb begin
    if (w_accept)                        w_sel = LOAD_PRODUCT;
    else if (r_state == CALC)            w_sel = ADD_SHIFT_PRODUCT;
    else if (r_state == FIXUP && r_negate) w_sel = NEG_PRODUCT;
    else                                 w_sel = HOLD_PRODUCT;
    w_productEn = (w_sel != HOLD_PRODUCT) ? TRUE : FALSE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_negate <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_mcand  <= w_absA;
          r_negate <= w_signA ^ w_signB;
          r_count  <= '0;
          r_busy   <= 1'b1;
          r_state  <= CALC;
        end
        CALC: begin
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH-1)) r_state <= FIXUP;
        end
        FIXUP: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  seq_multiplier_product_state #(.WIDTH(WIDTH)) u_product (
    .clk         (clk),
    .reset       (reset),
    .i_sel       (w_sel),
    .i_productEn (w_productEn),
    .i_mcand     (r_mcand),
    .i_mplr      (w_absB),
    .o_product   (w_product)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign productHigh = w_product[2*WIDTH-1:WIDTH];
  assign productLow  = w_product[WIDTH-1:0];
endmodule
